// File: rtl/rr_pop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rr_pop_ctrl
// Brief    : Round-robin pop controller draining four FIFOs into one push port.
//            Optional pop/valid protocol checker enabled by RR_POP_CTRL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================

module rr_pop_ctrl #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      fifo_empty,
  input  logic [3:0]      valid_in,
  input  logic [4*DW-1:0] data_in,
  input  logic            pause_in,
  output logic [3:0]      pop,
  output logic [DW-1:0]   data_out,
  output logic            push_out,
  output logic [1:0]      src_out,
  output logic            error_out
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_ACTIVE = 4'b0010,
    ST_PAUSE  = 4'b0100,
    ST_ERROR  = 4'b1000
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic            pend_vld_q, pend_vld_d;
  logic [1:0]      pend_src_q, pend_src_d;
  logic            push_q, push_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      src_q, src_d;

  logic            grant_vld;
  logic [1:0]      grant_idx;
  logic [1:0]      cand;
  logic            proto_err;
  logic            fwd;

  // Walk offsets from far to near so the index right after last_grant wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = last_grant_q + 2'(k) + 2'd1;
      if (!fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    pop = 4'b0000;
    if ((state_q == ST_ACTIVE) && !pause_in && grant_vld) begin
      pop = 4'b0001 << grant_idx;
    end
  end

`ifdef RR_POP_CTRL_CHECK_EN
  logic [3:0] expect_mask;
  logic       error_q, error_d;

  always_comb begin
    expect_mask = pend_vld_q ? (4'b0001 << pend_src_q) : 4'b0000;
    proto_err   = (|(valid_in & ~expect_mask)) | (pend_vld_q & ~valid_in[pend_src_q]);
    error_d     = error_q | proto_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_out = error_q;
`else
  always_comb begin
    proto_err = 1'b0;
  end

  assign error_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_ACTIVE;
      ST_ACTIVE: if (pause_in)  state_d = ST_PAUSE;
      ST_PAUSE:  if (!pause_in) state_d = ST_ACTIVE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    if (proto_err) begin
      state_d = ST_ERROR;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    pend_vld_d   = 1'b0;
    pend_src_d   = pend_src_q;
    if (pop != 4'b0000) begin
      last_grant_d = grant_idx;
      pend_vld_d   = 1'b1;
      pend_src_d   = grant_idx;
    end
  end

  // In-flight words are forwarded in every state except on or after an error.
  always_comb begin
    fwd    = pend_vld_q && valid_in[pend_src_q] && !proto_err && (state_q != ST_ERROR);
    push_d = fwd;
    data_d = data_q;
    src_d  = src_q;
    if (fwd) begin
      data_d = data_in[pend_src_q*DW +: DW];
      src_d  = pend_src_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      last_grant_q <= 2'd3;
      pend_vld_q   <= 1'b0;
      pend_src_q   <= 2'd0;
      push_q       <= 1'b0;
      data_q       <= '0;
      src_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pend_vld_q   <= pend_vld_d;
      pend_src_q   <= pend_src_d;
      push_q       <= push_d;
      data_q       <= data_d;
      src_q        <= src_d;
    end
  end

  assign push_out = push_q;
  assign data_out = data_q;
  assign src_out  = src_q;

endmodule

`default_nettype wire
